fp_mul_seq: RTL and testbench
=============================

Name: fp_mul_seq

Overview:
- Parametrised IEEE-754-style floating-point multiplier, multi-cycle. Generalises the existing single-precision combinational multiplier:
  - configurable exponent and mantissa widths;
  - round-to-nearest-even;
  - full special-value handling (zero, Inf, NaN);
  - valid/ready handshakes on both sides.
- Sits beside the ALU as a long-latency FP execution unit. The decode/stall logic holds the pipeline on in_ready/out_valid.
- Mantissa product is built by an iterative shift-add datapath (one partial product per cycle), trading latency for area.

Parameters:
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width; significand is MAN_W+1 bits with the hidden bit.
- Derived, not overridable: W = 1+EXP_W+MAN_W (32 at defaults).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, operands a/b valid.
- in_ready, output, 1, unit can accept operands.
- a, input, W, operand A (sign|exp|fraction).
- b, input, W, operand B.
- out_valid, output, 1, result valid; held until out_ready.
- out_ready, input, 1, consumer accepts result.
- result, output, W, product; registered; stable while out_valid=1.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Clock, reset and sampling:
  - One clock domain, clk. Reset is synchronous and active-high on reset, sampled only on the clk rising edge.
  - While reset=1: state=IDLE, in_ready=0, out_valid=0, busy=0, result=0, all datapath registers cleared.
  - in_ready goes high the first cycle after reset deasserts.
  - Reset mid-operation aborts the operation. The result is discarded; no out_valid pulse follows.
- States: IDLE, MUL, NORM, RND, DONE.
  - in_ready = (state==IDLE).
  - A transfer occurs on in_valid&&in_ready; call that edge cycle 0.
- Capture (cycle 0, entering MUL): register
  - sign = a[W-1]^b[W-1];
  - both exponent fields;
  - both significands.
- Denormals are treated as zero (DAZ): exponent field 0 means the operand is ±0 regardless of fraction.
- Classification, first MUL cycle (checked in this order, then go to DONE, out_valid at cycle 2):
  1. Either operand is NaN (exp all ones, fraction≠0) -> canonical quiet NaN: sign 0, exp all ones, fraction MSB 1, rest 0 (0x7FC00000 at defaults).
  2. Inf×0 or 0×Inf -> canonical NaN.
  3. Either operand is Inf -> signed Inf.
  4. Either operand is zero -> signed zero.
- MUL (normal operands):
  - MAN_W+1 cycles, one multiplier bit per cycle, LSB first, into a 2*(MAN_W+1)-bit accumulator.
  - Exponent sum is computed in EXP_W+2 signed bits: eA+eB-bias.
- NORM (1 cycle):
  - If product MSB is set: shift right by 1 and increment the exponent.
  - Extract the fraction, guard bit G, and sticky S = OR of all remaining low bits.
- RND (1 cycle), round to nearest even:
  - Increment the fraction if G && (S || lsb).
  - Fraction carry-out renormalises: fraction=0, exponent+1.
  - Exponent ≥ all ones -> signed Inf (overflow).
  - Exponent ≤ 0 -> signed zero (FTZ, underflow). Subnormal outputs are never produced.
- Latency for normal operands:
  - out_valid first high in cycle MAN_W+4 (27 at defaults).
  - Special cases: cycle 2.
- DONE:
  - out_valid=1 and result held until out_valid&&out_ready, then IDLE.
  - in_ready stays 0 in DONE, so no back-to-back accept in the same cycle.
  - Next accept is possible one cycle after the output handshake.
- in_valid while busy is ignored; the operands are not queued.
- Upstream must hold a/b stable only until the accepting edge.

Optional Feature:
- Macro FP_MUL_FLAGS_EN.
- When defined:
  - adds output port flags[3:0] = {invalid, overflow, underflow, inexact};
  - registered alongside result and valid only when out_valid=1 (0 otherwise and at reset);
  - invalid set for NaN results;
  - overflow set on Inf from finite operands;
  - underflow set on FTZ from nonzero operands;
  - inexact set when G|S ≠ 0, or on overflow/underflow.
- When undefined: no flags port and no flag logic. All other behaviour is identical.

Test Plan:
- Reset, then a=0x3FC00000 (1.5), b=0x40000000 (2.0), out_ready=1 -> in_ready drops at cycle 1; out_valid in cycle 27 only; result=0x40400000; busy low the cycle after the handshake.
- a=0xC0000000 (-2.0), b=0x40400000 (3.0) -> result 0xC0C00000; out_ready held 0 for 5 cycles -> result and out_valid remain stable, in_ready stays 0.
- Rounding: 0x3F800001×0x3F800001 -> 0x3F800002 (below half, truncate); 0x3F800001×0x3FC00000 -> 0x3FC00002 (tie, round to even); flags inexact=1 when FP_MUL_FLAGS_EN is defined.
- Specials:
  - 0x7F800000×0x00000000 -> 0x7FC00000 at cycle 2 (invalid=1);
  - 0xFF800000×0x40000000 -> 0xFF800000;
  - 0x00000001(denormal)×0x3F800000 -> 0x00000000.
- Range: 0x7F7FFFFF×0x40000000 -> 0x7F800000 (overflow=1); 0x00800000×0x3F000000 -> 0x00000000 (underflow=1, inexact=1).
- Assert reset at cycle 10 of an operation -> next cycle in IDLE, out_valid never asserts; a new operation immediately after yields its correct result.

Source files
------------

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multi-cycle IEEE-754-style multiplier with a shift-add significand datapath,
// round-to-nearest-even, DAZ inputs and FTZ outputs. Define FP_MUL_FLAGS_EN to add the flags output.
module fp_mul_seq #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
`ifdef FP_MUL_FLAGS_EN
  output logic [3:0]   flags,
`endif
  output logic         busy
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int CNT_W  = $clog2(SIG_W);

  localparam logic signed [EXP_W+1:0] BIAS     = (EXP_W+2)'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'((2 ** EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ZERO = (EXP_W+2)'(0);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(MAN_W);
  localparam logic [W-1:0]            QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_NORM = 3'd2,
    ST_RND  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                   state_q;
  logic                     in_ready_q;
  logic                     busy_q;
  logic                     out_valid_q;
  logic [W-1:0]             result_q;
  logic                     sign_q;
  logic [EXP_W-1:0]         ea_q;
  logic [EXP_W-1:0]         eb_q;
  logic [PROD_W-1:0]        mcand_q;
  logic [SIG_W-1:0]         mplier_q;
  logic [PROD_W-1:0]        acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [EXP_W+1:0]  exp_q;
  logic [MAN_W-1:0]         frac_q;
  logic                     g_q;
  logic                     s_q;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]               flags_q;
`endif

  logic                     a_ones_s, b_ones_s, a_zero_s, b_zero_s, a_fnz_s, b_fnz_s;
  logic                     spec_s, spec_nan_s;
  logic [W-1:0]             spec_res_s;
  logic signed [EXP_W+1:0]  exp_sum_d;
  logic                     prod_msb_s;
  logic [PROD_W-2:0]        norm_s;
  logic [MAN_W-1:0]         frac_d;
  logic                     g_d, s_d;
  logic                     round_up_s;
  logic [MAN_W:0]           frac_inc_s;
  logic signed [EXP_W+1:0]  exp_rnd_s;
  logic                     ovf_s, unf_s;
  logic [W-1:0]             rnd_res_s;

  // Operand classification; the fraction bits sit untouched in the low bits until the first MUL step.
  always_comb begin
    a_ones_s   = &ea_q;
    b_ones_s   = &eb_q;
    a_zero_s   = ~|ea_q;
    b_zero_s   = ~|eb_q;
    a_fnz_s    = |mcand_q[MAN_W-1:0];
    b_fnz_s    = |mplier_q[MAN_W-1:0];
    spec_s     = a_ones_s | b_ones_s | a_zero_s | b_zero_s;
    spec_nan_s = (a_ones_s && a_fnz_s) || (b_ones_s && b_fnz_s) ||
                 (a_ones_s && b_zero_s) || (a_zero_s && b_ones_s);
    if (spec_nan_s) begin
      spec_res_s = QNAN;
    end else if (a_ones_s || b_ones_s) begin
      spec_res_s = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      spec_res_s = {sign_q, {(W-1){1'b0}}};
    end
    exp_sum_d = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS;
  end

  // Normalise the product so the hidden bit drops off the top, then split fraction/guard/sticky.
  always_comb begin
    prod_msb_s = acc_q[PROD_W-1];
    if (prod_msb_s) begin
      norm_s = acc_q[PROD_W-2:0];
    end else begin
      norm_s = {acc_q[PROD_W-3:0], 1'b0};
    end
    frac_d = norm_s[PROD_W-2:MAN_W+1];
    g_d    = norm_s[MAN_W];
    s_d    = |norm_s[MAN_W-1:0];
  end

  // Round to nearest even, renormalise on carry-out, then saturate to Inf or flush to zero.
  always_comb begin
    round_up_s = g_q && (s_q || frac_q[0]);
    frac_inc_s = {1'b0, frac_q} + {{MAN_W{1'b0}}, round_up_s};
    exp_rnd_s  = exp_q + $signed({{(EXP_W+1){1'b0}}, frac_inc_s[MAN_W]});
    ovf_s      = (exp_rnd_s >= EXP_MAX);
    unf_s      = (exp_rnd_s <= EXP_ZERO);
    if (ovf_s) begin
      rnd_res_s = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (unf_s) begin
      rnd_res_s = {sign_q, {(W-1){1'b0}}};
    end else begin
      rnd_res_s = {sign_q, exp_rnd_s[EXP_W-1:0], frac_inc_s[MAN_W-1:0]};
    end
  end

  // Control FSM with the datapath and all output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      frac_q      <= '0;
      g_q         <= 1'b0;
      s_q         <= 1'b0;
`ifdef FP_MUL_FLAGS_EN
      flags_q     <= 4'b0000;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            sign_q     <= a[W-1] ^ b[W-1];
            ea_q       <= a[W-2:MAN_W];
            eb_q       <= b[W-2:MAN_W];
            mcand_q    <= {{SIG_W{1'b0}}, |a[W-2:MAN_W], a[MAN_W-1:0]};
            mplier_q   <= {|b[W-2:MAN_W], b[MAN_W-1:0]};
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_MUL;
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        ST_MUL: begin
          if ((cnt_q == {CNT_W{1'b0}}) && spec_s) begin
            result_q    <= spec_res_s;
            out_valid_q <= 1'b1;
`ifdef FP_MUL_FLAGS_EN
            flags_q     <= {spec_nan_s, 3'b000};
`endif
            state_q     <= ST_DONE;
          end else begin
            if (mplier_q[0]) begin
              acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == {CNT_W{1'b0}}) begin
              exp_q <= exp_sum_d;
            end
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
          frac_q  <= frac_d;
          g_q     <= g_d;
          s_q     <= s_d;
          exp_q   <= exp_q + $signed({{(EXP_W+1){1'b0}}, prod_msb_s});
          state_q <= ST_RND;
        end
        ST_RND: begin
          result_q    <= rnd_res_s;
          out_valid_q <= 1'b1;
`ifdef FP_MUL_FLAGS_EN
          flags_q     <= {1'b0, ovf_s, unf_s, g_q | s_q | ovf_s | unf_s};
`endif
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef FP_MUL_FLAGS_EN
            flags_q     <= 4'b0000;
`endif
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
`ifdef FP_MUL_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq (single precision): directed cases plus randomized
// operands checked against an arithmetic reference model.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checks = 0;
  int errors = 0;

  fp_mul_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef FP_MUL_FLAGS_EN
    .flags     (flags),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, rounded by comparing the discarded part against one half.
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f, output bit spec);
    logic        s;
    logic        xn, yn, xi, yi, xz, yz;
    logic [63:0] p, keep, rem, half;
    int          e;
    s  = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    spec = 1'b1;
    f = 4'b0000;
    if (xn || yn || (xi && yz) || (xz && yi)) begin
      r = 32'h7FC00000;
      f = 4'b1000;
    end else if (xi || yi) begin
      r = {s, 8'hFF, 23'd0};
    end else if (xz || yz) begin
      r = {s, 31'd0};
    end else begin
      spec = 1'b0;
      p = {40'd0, 1'b1, x[22:0]} * {40'd0, 1'b1, y[22:0]};
      e = int'(x[30:23]) + int'(y[30:23]) - 127;
      if (p[47]) begin
        keep = p >> 24; rem = p & 64'hFFFFFF; half = 64'h800000; e = e + 1;
      end else begin
        keep = p >> 23; rem = p & 64'h7FFFFF; half = 64'h400000;
      end
      f[0] = (rem != 64'd0);
      if ((rem > half) || ((rem == half) && keep[0])) keep = keep + 64'd1;
      if (keep[24]) begin
        keep = keep >> 1; e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0}; f[2] = 1'b1; f[0] = 1'b1;
      end else if (e <= 0) begin
        r = {s, 31'd0}; f[1] = 1'b1; f[0] = 1'b1;
      end else begin
        r = {s, 8'(e), keep[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] gen_operand();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = 1'($urandom);
    f = 23'($urandom);
    case ($urandom_range(0, 15))
      0: e = 8'd0;
      1: begin e = 8'hFF; f = 23'd0; end
      2: begin e = 8'hFF; f = f | 23'd1; end
      3: e = 8'($urandom_range(200, 254));
      4: e = 8'($urandom_range(1, 40));
      5: begin e = 8'($urandom_range(100, 150)); f = f & 23'h7E0000; end
      default: e = 8'($urandom_range(90, 165));
    endcase
    return {s, e, f};
  endfunction

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    int guard;
    guard = 0;
    a = av; b = bv; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready never rose for a=%h b=%h", av, bv);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic wait_result(input int lat0, output logic [31:0] res, output int lat);
    lat = lat0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    res = result;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got {in_ready,out_valid,busy}=%b expected 000", {in_ready, out_valid, busy});
    end
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_result: got %h expected 00000000", result);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: in_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] got;
    int          lat;
    start_op(32'h3FC00000, 32'h40000000);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_cycle1: in_ready=%b busy=%b expected 0/1", in_ready, busy);
    end
    wait_result(1, got, lat);
    checks++;
    if (lat !== 27) begin
      errors++; $display("FAIL basic_latency: got %0d expected 27", lat);
    end
    checks++;
    if (got !== 32'h40400000) begin
      errors++; $display("FAIL basic_result: got %h expected 40400000", got);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_after_hs: out_valid=%b busy=%b in_ready=%b expected 0/0/1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got;
    int          lat;
    bit          stable;
    out_ready = 1'b0;
    start_op(32'hC0000000, 32'h40400000);
    wait_result(0, got, lat);
    checks++;
    if (got !== 32'hC0C00000 || lat !== 27) begin
      errors++; $display("FAIL bp_result: got %h at cycle %0d expected C0C00000 at 27", got, lat);
    end
    in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 32'hC0C00000 || in_ready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL bp_hold: out_valid=%b result=%h in_ready=%b expected 1/C0C00000/0", out_valid, result, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: out_valid=%b busy=%b expected 0/0", out_valid, busy);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] ta [0:1];
    logic [31:0] tb [0:1];
    logic [31:0] tr [0:1];
    logic [31:0] got;
    int          lat;
    ta = '{32'h3F800001, 32'h3F800001};
    tb = '{32'h3F800001, 32'h3FC00000};
    tr = '{32'h3F800002, 32'h3FC00002};
    for (int i = 0; i < 2; i++) begin
      start_op(ta[i], tb[i]);
      wait_result(0, got, lat);
      checks++;
      if (got !== tr[i]) begin
        errors++; $display("FAIL round_%0d: got %h expected %h", i, got, tr[i]);
      end
`ifdef FP_MUL_FLAGS_EN
      checks++;
      if (flags !== 4'b0001) begin
        errors++; $display("FAIL round_flags_%0d: got %b expected 0001", i, flags);
      end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_specials();
    logic [31:0] ta [0:2];
    logic [31:0] tb [0:2];
    logic [31:0] tr [0:2];
    logic [3:0]  tf [0:2];
    logic [31:0] got;
    int          lat;
    ta = '{32'h7F800000, 32'hFF800000, 32'h00000001};
    tb = '{32'h00000000, 32'h40000000, 32'h3F800000};
    tr = '{32'h7FC00000, 32'hFF800000, 32'h00000000};
    tf = '{4'b1000, 4'b0000, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i]);
      wait_result(0, got, lat);
      checks++;
      if (got !== tr[i] || lat !== 2) begin
        errors++; $display("FAIL special_%0d: got %h at cycle %0d expected %h at 2", i, got, lat, tr[i]);
      end
`ifdef FP_MUL_FLAGS_EN
      checks++;
      if (flags !== tf[i]) begin
        errors++; $display("FAIL special_flags_%0d: got %b expected %b", i, flags, tf[i]);
      end
`else
      if (tf[i] == 4'b1111) $display("unused flag vector %b", tf[i]);
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_range();
    logic [31:0] ta [0:1];
    logic [31:0] tb [0:1];
    logic [31:0] tr [0:1];
    logic [3:0]  tf [0:1];
    logic [31:0] got;
    int          lat;
    ta = '{32'h7F7FFFFF, 32'h00800000};
    tb = '{32'h40000000, 32'h3F000000};
    tr = '{32'h7F800000, 32'h00000000};
    tf = '{4'b0101, 4'b0011};
    for (int i = 0; i < 2; i++) begin
      start_op(ta[i], tb[i]);
      wait_result(0, got, lat);
      checks++;
      if (got !== tr[i] || lat !== 27) begin
        errors++; $display("FAIL range_%0d: got %h at cycle %0d expected %h at 27", i, got, lat, tr[i]);
      end
`ifdef FP_MUL_FLAGS_EN
      checks++;
      if (flags !== tf[i]) begin
        errors++; $display("FAIL range_flags_%0d: got %b expected %b", i, flags, tf[i]);
      end
`else
      if (tf[i] == 4'b1111) $display("unused flag vector %b", tf[i]);
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    int          lat;
    start_op(32'h3FC00000, 32'h40000000);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, out_valid, in_ready} !== 3'b000) begin
      errors++; $display("FAIL midreset_state: {busy,out_valid,in_ready}=%b expected 000", {busy, out_valid, in_ready});
    end
    reset = 1'b0;
    start_op(32'h40000000, 32'h40400000);
    wait_result(0, got, lat);
    checks++;
    if (got !== 32'h40C00000 || lat !== 27) begin
      errors++; $display("FAIL midreset_next: got %h at cycle %0d expected 40C00000 at 27", got, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int          lat;
    start_op(32'h40400000, 32'h40400000);
    wait_result(0, got, lat);
    checks++;
    if (got !== 32'h41100000) begin
      errors++; $display("FAIL b2b_first: got %h expected 41100000", got);
    end
    a = 32'h40A00000; b = 32'h3F000000; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_done_ready: in_ready got %b expected 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: busy got %b expected 1", busy);
    end
    wait_result(1, got, lat);
    checks++;
    if (got !== 32'h40200000 || lat !== 27) begin
      errors++; $display("FAIL b2b_second: got %h at cycle %0d expected 40200000 at 27", got, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] x, y, er, got;
    logic [3:0]  ef;
    bit          es;
    int          lat;
    for (int i = 0; i < 150; i++) begin
      x = gen_operand();
      y = gen_operand();
      ref_mul(x, y, er, ef, es);
      start_op(x, y);
      wait_result(0, got, lat);
      checks++;
      if (got !== er) begin
        errors++; $display("FAIL rand_result: %h x %h got %h expected %h", x, y, got, er);
      end
      checks++;
      if (lat !== (es ? 2 : 27)) begin
        errors++; $display("FAIL rand_latency: %h x %h got %0d expected %0d", x, y, lat, es ? 2 : 27);
      end
`ifdef FP_MUL_FLAGS_EN
      checks++;
      if (flags !== ef) begin
        errors++; $display("FAIL rand_flags: %h x %h got %b expected %b", x, y, flags, ef);
      end
`endif
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    a = 32'h0;
    b = 32'h0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_rounding();
    test_specials();
    test_range();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
